// File: rtl/pio_in_edge_capture_pkg.sv
// pio_in_edge_capture_pkg: register map and edge-type encodings shared by the input PIO
package pio_in_edge_capture_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: input synchroniser chain, previous-value register and edge vector
module pio_sync_edge
    import pio_in_edge_capture_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_val_o,
    output logic [WIDTH-1:0] edge_o
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    always_comb begin
        sync_val_o = sync_q[SYNC_STAGES-1];
        edge_o = (EDGE_TYPE == EDGE_RISING)  ? (sync_val_o & ~prev_q) :
                 (EDGE_TYPE == EDGE_FALLING) ? (~sync_val_o & prev_q) :
                                               (sync_val_o ^ prev_q);
    end
endmodule

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture: Avalon-MM input PIO with sticky edge capture and masked level irq
module pio_in_edge_capture
    import pio_in_edge_capture_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int BIT_CLEAR   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync_val, edge_vec, clr;
    logic [WIDTH-1:0] mask_q, mask_d, edge_q, edge_d;
    logic [31:0] readdata_q, readdata_d;
    logic wr, unused_wd;
    pio_sync_edge #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE(EDGE_TYPE)
    ) u_sync (
        .clk(clk),
        .reset_n(reset_n),
        .in_i(in_port),
        .sync_val_o(sync_val),
        .edge_o(edge_vec)
    );
    // a fresh edge outranks a clear landing in the same cycle
    always_comb begin
        wr = chipselect && !write_n;
        clr = (wr && address == ADDR_EDGE) ? ((BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1) : '0;
        edge_d = (edge_q & ~clr) | edge_vec;
        mask_d = (wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        readdata_d = (address == ADDR_DATA) ? 32'(sync_val) :
                     (address == ADDR_MASK) ? 32'(mask_q) :
                     (address == ADDR_EDGE) ? 32'(edge_q) : 32'h0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
        end
    end
    assign readdata  = readdata_q;
    assign irq       = |(edge_q & mask_q);
    assign unused_wd = ^writedata;
endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb_pio_in_edge_capture: directed checks on rising/W1C, rising/clear-all and any-edge instances
module tb_pio_in_edge_capture;
    logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
    logic [1:0] address = 0;
    logic [31:0] writedata = 0;
    logic [1:0] in_a = 2'b11, in_b = 2'b11, in_c = 2'b11;
    logic [31:0] readdata_a, readdata_b, readdata_c, rd_a, rd_b, rd_c;
    logic irq_a, irq_b, irq_c;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    pio_in_edge_capture #(.EDGE_TYPE(0), .BIT_CLEAR(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(readdata_a), .irq(irq_a));
    pio_in_edge_capture #(.EDGE_TYPE(0), .BIT_CLEAR(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b), .readdata(readdata_b), .irq(irq_b));
    pio_in_edge_capture #(.EDGE_TYPE(2), .BIT_CLEAR(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_c), .readdata(readdata_c), .irq(irq_c));

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1; write_n = 0;
        @(negedge clk);
        chipselect = 0; write_n = 1; writedata = 0;
    endtask

    task automatic read_reg(input logic [1:0] a);
        address = a; chipselect = 1;
        @(negedge clk);
        rd_a = readdata_a; rd_b = readdata_b; rd_c = readdata_c;
        chipselect = 0;
    endtask

    task automatic test_reset;
        step(2);
        n_cmp++; if (readdata_a !== 32'h0 || irq_a !== 1'b0) begin n_bad++; $display("FAIL in_reset: rd=%h irq=%b want 0/0", readdata_a, irq_a); end
        reset_n = 1; address = 2'd0; chipselect = 1;
        step(1);
        n_cmp++; if (readdata_a !== 32'h0) begin n_bad++; $display("FAIL data_cyc1: got %h want 0", readdata_a); end
        step(1);
        n_cmp++; if (readdata_a !== 32'h0) begin n_bad++; $display("FAIL data_cyc2: got %h want 0", readdata_a); end
        step(1);
        n_cmp++; if (readdata_a !== 32'h3) begin n_bad++; $display("FAIL data_cyc3: got %h want 3", readdata_a); end
        read_reg(2'd1);
        n_cmp++; if (rd_a !== 32'h0) begin n_bad++; $display("FAIL dir_read: got %h want 0", rd_a); end
        read_reg(2'd2);
        n_cmp++; if (rd_a !== 32'h0) begin n_bad++; $display("FAIL mask_read: got %h want 0", rd_a); end
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h3 || rd_b !== 32'h3 || rd_c !== 32'h3) begin n_bad++; $display("FAIL first_edge: got %h/%h/%h want 3/3/3", rd_a, rd_b, rd_c); end
        n_cmp++; if (irq_a !== 1'b0) begin n_bad++; $display("FAIL irq_unmasked: got %b want 0", irq_a); end
        write_reg(2'd3, 32'h3);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h0 || rd_b !== 32'h0 || rd_c !== 32'h0) begin n_bad++; $display("FAIL reset_clear: got %h/%h/%h want 0/0/0", rd_a, rd_b, rd_c); end
    endtask

    task automatic test_rising;
        write_reg(2'd2, 32'h1);
        in_a = 2'b00;
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h0) begin n_bad++; $display("FAIL fall_ignored: got %h want 0", rd_a); end
        in_a = 2'b01;
        step(2);
        n_cmp++; if (irq_a !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", irq_a); end
        step(1);
        n_cmp++; if (irq_a !== 1'b1) begin n_bad++; $display("FAIL irq_edge3: got %b want 1", irq_a); end
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h1) begin n_bad++; $display("FAIL rise_cap: got %h want 1", rd_a); end
        in_a = 2'b00;
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h1 || irq_a !== 1'b1) begin n_bad++; $display("FAIL fall_no_cap: got %h irq=%b want 1/1", rd_a, irq_a); end
        n_cmp++; if (irq_b !== 1'b0) begin n_bad++; $display("FAIL irq_b_idle: got %b want 0", irq_b); end
    endtask

    task automatic test_masked;
        write_reg(2'd3, 32'h1);
        in_a = 2'b10;
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h2 || irq_a !== 1'b0) begin n_bad++; $display("FAIL masked_cap: got %h irq=%b want 2/0", rd_a, irq_a); end
        write_reg(2'd2, 32'h3);
        n_cmp++; if (irq_a !== 1'b1) begin n_bad++; $display("FAIL unmask_irq: got %b want 1", irq_a); end
        write_reg(2'd2, 32'h0);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h2 || irq_a !== 1'b0) begin n_bad++; $display("FAIL mask_keeps_cap: got %h irq=%b want 2/0", rd_a, irq_a); end
        write_reg(2'd2, 32'hFFFF_FFFF);
        read_reg(2'd2);
        n_cmp++; if (rd_a !== 32'h3) begin n_bad++; $display("FAIL mask_upper: got %h want 3", rd_a); end
    endtask

    task automatic test_clear;
        in_a = 2'b11; in_b = 2'b00;
        step(4);
        in_b = 2'b11;
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h3 || rd_b !== 32'h3) begin n_bad++; $display("FAIL pre_clear: got %h/%h want 3/3", rd_a, rd_b); end
        write_reg(2'd3, 32'h1);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h2 || rd_b !== 32'h0) begin n_bad++; $display("FAIL clear_bit0: got %h/%h want 2/0", rd_a, rd_b); end
        in_b = 2'b00;
        step(4);
        in_b = 2'b11;
        step(4);
        write_reg(2'd3, 32'h0);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h2 || rd_b !== 32'h0) begin n_bad++; $display("FAIL clear_zero: got %h/%h want 2/0", rd_a, rd_b); end
        write_reg(2'd3, 32'h2);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h0 || irq_a !== 1'b0) begin n_bad++; $display("FAIL clear_bit1: got %h irq=%b want 0/0", rd_a, irq_a); end
    endtask

    task automatic test_back_to_back;
        in_a = 2'b10;
        step(4);
        in_a = 2'b11;
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h1 || irq_a !== 1'b1) begin n_bad++; $display("FAIL b2b_setup: got %h irq=%b want 1/1", rd_a, irq_a); end
        in_a = 2'b10;
        step(4);
        in_a = 2'b11;
        step(2);
        write_reg(2'd3, 32'h1);
        n_cmp++; if (irq_a !== 1'b1) begin n_bad++; $display("FAIL setclr_irq: got %b want 1", irq_a); end
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h1) begin n_bad++; $display("FAIL setclr_cap: got %h want 1", rd_a); end
        write_reg(2'd3, 32'h1);
        read_reg(2'd3);
        n_cmp++; if (rd_a !== 32'h0 || irq_a !== 1'b0) begin n_bad++; $display("FAIL plain_clear: got %h irq=%b want 0/0", rd_a, irq_a); end
    endtask

    task automatic test_any_reset;
        in_c = 2'b10;
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_c !== 32'h1 || irq_c !== 1'b1) begin n_bad++; $display("FAIL any_fall: got %h irq=%b want 1/1", rd_c, irq_c); end
        write_reg(2'd3, 32'h1);
        read_reg(2'd3);
        n_cmp++; if (rd_c !== 32'h0) begin n_bad++; $display("FAIL any_clear: got %h want 0", rd_c); end
        in_c = 2'b11;
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_c !== 32'h1) begin n_bad++; $display("FAIL any_rise: got %h want 1", rd_c); end
        in_c = 2'b10;
        step(1);
        reset_n = 0;
        #1;
        n_cmp++; if (irq_c !== 1'b0 || readdata_c !== 32'h0) begin n_bad++; $display("FAIL async_reset: irq=%b rd=%h want 0/0", irq_c, readdata_c); end
        @(negedge clk);
        reset_n = 1;
        read_reg(2'd2);
        n_cmp++; if (rd_c !== 32'h0 || rd_a !== 32'h0) begin n_bad++; $display("FAIL reset_mask: got %h/%h want 0/0", rd_c, rd_a); end
        read_reg(2'd3);
        n_cmp++; if (rd_c !== 32'h0) begin n_bad++; $display("FAIL reset_cap: got %h want 0", rd_c); end
        step(4);
        read_reg(2'd3);
        n_cmp++; if (rd_c !== 32'h2 || irq_c !== 1'b0) begin n_bad++; $display("FAIL post_reset_cap: got %h irq=%b want 2/0", rd_c, irq_c); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_masked();
        test_clear();
        test_back_to_back();
        test_any_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pio_in_edge_capture.md
Name: pio_in_edge_capture

Overview:
Avalon-MM slave input PIO, the read-side counterpart of the team's 2-bit output PIO in the Qsys system.
- Synchronises a WIDTH-bit external input bus and exposes it to the Nios II.
- Latches selected edges into a sticky edge-capture register.
- Raises a level interrupt for captured edges whose mask bit is set.

Parameters:
WIDTH, 2, width of in_port and of all per-bit registers (1..32)
SYNC_STAGES, 2, synchroniser flop count on in_port (>=2)
EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge
BIT_CLEAR, 1, 1 = edge capture write-1-to-clear per bit; 0 = any write to address 3 clears all bits

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
in_port  in  WIDTH  external asynchronous input bus
readdata  out  32  Avalon read data, registered
irq  out  1  level interrupt, active-high

Behaviour:
- Reset: all synchroniser flops, prev, irq_mask, edge_capture and readdata = 0; irq = 0.
- Synchroniser: chain of SYNC_STAGES flops per bit. sync_val = last stage.
- prev register: loads sync_val every cycle.
- Edge vector:
  - rising: sync_val & ~prev
  - falling: ~sync_val & prev
  - any: sync_val ^ prev
- Latency: an in_port change is visible in sync_val after SYNC_STAGES clk edges. edge_capture sets on the next edge, i.e. SYNC_STAGES+1 edges after the change. irq follows in the same cycle (combinational from registers).
- First edge after reset: an input held high at reset release is reported as a rising edge. This is intentional.
- Register map (word addresses):
  - 0 data: read sync_val zero-extended; writes ignored.
  - 1 direction: reads 0; writes ignored.
  - 2 irq_mask: read/write of bits [WIDTH-1:0]; upper bits read 0.
  - 3 edge_capture: read sticky bits. Write clears per BIT_CLEAR.
- Write qualifier: chipselect && !write_n. No wait states.
- Read path: readdata registered every cycle from the current address. Valid one clk after address/chipselect presented (readLatency = 1). Reads have no side effects.
- edge_capture update per bit: next = (cur & ~clr) | edge. A new edge in the same cycle as a clear of that bit wins, so the bit stays 1.
- irq = |(edge_capture & irq_mask). It stays asserted until software clears the bits or masks them.
- Mask change: takes effect on irq the cycle after the write edge. Masking does not clear edge_capture.
- Mid-operation reset: everything returns to reset values immediately (asynchronous). Pending captures are lost.
- readdata bits above WIDTH always 0.

Decomposition:
- Shared package holds:
  - register address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings
- One natural sub-module: pio_sync_edge, covering the per-bus synchroniser, prev register and edge vector generation (params WIDTH, SYNC_STAGES, EDGE_TYPE; outputs sync_val, edge).
- Top level keeps the register file, read mux and irq.

Test Plan:
- Reset/readback: hold reset_n=0, in_port=2'b11, release → reads return 0 until sync completes. Read addr0 = 0x3 after 3 cycles. Addr1 = 0. Addr2 = 0.
- Rising capture + irq: EDGE_TYPE=0, write mask=2'b01. Drive in_port 00→01.
  - edge_capture = 0x1 and irq=1 exactly 3 clk edges after the change.
  - 01→00 produces no new capture.
- Masked edge: mask=2'b01, in_port bit1 rises → edge_capture=0x2, irq stays 0. Then write mask=2'b11 → irq=1 the next cycle.
- Clear semantics: BIT_CLEAR=1, edge_capture=0x3, write 0x1 to addr3 → reads 0x2. With BIT_CLEAR=0, any write to addr3 → 0x0.
- Simultaneous set/clear: arrange a bit0 edge in the same cycle as a write of 0x1 to addr3 → edge_capture bit0 remains 1 and irq remains 1.
- Any-edge + mid-op reset: EDGE_TYPE=2, toggle bit0 twice → bit captured. Assert reset_n mid-sequence → edge_capture, mask and irq = 0 immediately, with no capture from the pre-reset toggle.
